// File: rtl/apb_master_bridge_pkg.sv
// Shared types and constants for the APB master bridge and its address decoder.
package apb_master_bridge_pkg;

  localparam int unsigned APB_SEL_BITS = 2;

  typedef enum logic [1:0] {
    MST_IDLE   = 2'd0,
    MST_SETUP  = 2'd1,
    MST_ACCESS = 2'd2
  } mst_state_e;

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps the slave-select address bits onto one-hot PSEL lines; flags selects
// beyond the populated slave count.
module apb_addr_decoder
  import apb_master_bridge_pkg::*;
#(
  parameter int unsigned NO_SLAVES = 1
) (
  input  logic [APB_SEL_BITS-1:0] i_sel_bits,
  output logic [NO_SLAVES-1:0]    o_sel_oh_c,
  output logic                    o_decode_err_c
);

  always_comb begin
    o_sel_oh_c     = '0;
    o_decode_err_c = 1'b1;
    for (int unsigned i = 0; i < NO_SLAVES; i++) begin
      if (i_sel_bits == APB_SEL_BITS'(i)) begin
        o_sel_oh_c[i]  = 1'b1;
        o_decode_err_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-master APB3 requester: turns valid/ready commands into SETUP/ACCESS
// transfers with ready masking, timeout abort and a one-cycle response strobe.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned ADDR_WIDTH        = 16,
  parameter int unsigned NO_SLAVES         = 1,
  parameter int unsigned TIMEOUT_CYCLES    = 16,
  parameter int unsigned READY_MASK_CYCLES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [NO_SLAVES-1:0]  PSELx,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PENABLE,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  localparam int unsigned CNT_PEAK = (TIMEOUT_CYCLES > READY_MASK_CYCLES) ?
                                     TIMEOUT_CYCLES : READY_MASK_CYCLES;
  localparam int unsigned WCNT_W   = $clog2(CNT_PEAK + 2);
  // Last ACCESS cycle index before abort, so exactly TIMEOUT_CYCLES ACCESS cycles run.
  localparam int unsigned TO_LAST  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [WCNT_W-1:0] WCNT_SAT = '1;

  mst_state_e            r_state;
  mst_state_e            w_state_nxt;
  logic [WCNT_W-1:0]     r_wait_cnt;

  logic                  w_accept;
  logic                  w_dec_err;
  logic [NO_SLAVES-1:0]  w_dec_oh;
  logic                  w_ready_ok;
  logic                  w_timeout;

  logic                  r_cmd_ready,  w_cmd_ready_nxt;
  logic                  r_rsp_valid,  w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata,  w_rsp_rdata_nxt;
  logic                  r_rsp_err,    w_rsp_err_nxt;
  logic                  r_busy,       w_busy_nxt;
  logic [NO_SLAVES-1:0]  r_psel,       w_psel_nxt;
  logic [ADDR_WIDTH-1:0] r_paddr,      w_paddr_nxt;
  logic                  r_pwrite,     w_pwrite_nxt;
  logic [DATA_WIDTH-1:0] r_pwdata,     w_pwdata_nxt;
  logic                  r_penable,    w_penable_nxt;

  apb_addr_decoder #(
    .NO_SLAVES (NO_SLAVES)
  ) u_addr_decoder (
    .i_sel_bits     (cmd_addr[ADDR_WIDTH-1 -: APB_SEL_BITS]),
    .o_sel_oh_c     (w_dec_oh),
    .o_decode_err_c (w_dec_err)
  );

  assign w_accept   = cmd_valid & r_cmd_ready & (r_state == MST_IDLE);
  assign w_ready_ok = (r_state == MST_ACCESS) && PREADY &&
                      (r_wait_cnt >= WCNT_W'(READY_MASK_CYCLES));
  // A valid PREADY always beats the timeout in the same cycle.
  assign w_timeout  = (r_state == MST_ACCESS) && (TIMEOUT_CYCLES != 0) && !w_ready_ok &&
                      (r_wait_cnt >= WCNT_W'(TO_LAST));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= MST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MST_IDLE:   if (w_accept && !w_dec_err) w_state_nxt = MST_SETUP;
      MST_SETUP:  w_state_nxt = MST_ACCESS;
      MST_ACCESS: if (w_ready_ok || w_timeout) w_state_nxt = MST_IDLE;
      default:    w_state_nxt = MST_IDLE;
    endcase
  end

  // Next values of the registered outputs; bus address/control/data hold by default.
  always_comb begin
    w_cmd_ready_nxt = (w_state_nxt == MST_IDLE);
    w_busy_nxt      = (w_state_nxt != MST_IDLE);
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = '0;
    w_rsp_err_nxt   = 1'b0;
    w_psel_nxt      = r_psel;
    w_paddr_nxt     = r_paddr;
    w_pwrite_nxt    = r_pwrite;
    w_pwdata_nxt    = r_pwdata;
    w_penable_nxt   = 1'b0;
    case (r_state)
      MST_IDLE: begin
        w_psel_nxt = '0;
        if (w_accept) begin
          if (w_dec_err) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
          end else begin
            w_psel_nxt   = w_dec_oh;
            w_paddr_nxt  = cmd_addr;
            w_pwrite_nxt = cmd_write;
            w_pwdata_nxt = cmd_wdata;
          end
        end
      end
      MST_SETUP: w_penable_nxt = 1'b1;
      MST_ACCESS: begin
        if (w_ready_ok) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = PSLVERR;
          w_rsp_rdata_nxt = (!r_pwrite && !PSLVERR) ? PRDATA : '0;
          w_psel_nxt      = '0;
        end else if (w_timeout) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_psel_nxt      = '0;
        end else begin
          w_penable_nxt   = 1'b1;
        end
      end
      default: w_psel_nxt = '0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wait_cnt  <= '0;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_psel      <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_penable   <= 1'b0;
    end else begin
      if (w_state_nxt == MST_SETUP) begin
        r_wait_cnt <= '0;
      end else if (r_state == MST_ACCESS && r_wait_cnt != WCNT_SAT) begin
        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
      end
      r_cmd_ready <= w_cmd_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_psel      <= w_psel_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_penable   <= w_penable_nxt;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSELx     = r_psel;
  assign PADDR     = r_paddr;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;
  assign PENABLE   = r_penable;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: directed commands push expected
// responses; a negedge monitor checks bus phases and each response strobe.
module tb_apb_master_bridge;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned NS = 1;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;
  logic [NS-1:0] PSELx;
  logic [AW-1:0] PADDR;
  logic          PWRITE, PENABLE;
  logic [DW-1:0] PWDATA;
  logic          PREADY  = 1'b0;
  logic [DW-1:0] PRDATA  = '0;
  logic          PSLVERR = 1'b0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          err;
    logic [DW-1:0] rdata;
    int            acc;
    int            setup;
    int            acc_cyc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            ready_at = 0;
  logic          stale_ready = 1'b0;
  logic [DW-1:0] slave_rdata = '0;
  logic          slave_err   = 1'b0;
  int            acc_n = 0;
  int            mon_acc = 0, mon_setup = 0;
  int            rsp_count = 0, last_rsp_cyc = 0, last_gap = 0;
  int            snap;

  apb_master_bridge #(
    .DATA_WIDTH        (DW),
    .ADDR_WIDTH        (AW),
    .NO_SLAVES         (NS),
    .TIMEOUT_CYCLES    (16),
    .READY_MASK_CYCLES (2)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .PSELx     (PSELx),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PENABLE   (PENABLE),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERR   (PSLVERR)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 0);
    chk({tag, "_busy"},      32'(busy), 0);
    chk({tag, "_psel"},      32'(PSELx), 0);
    chk({tag, "_paddr"},     32'(PADDR), 0);
    chk({tag, "_pwrite"},    32'(PWRITE), 0);
    chk({tag, "_pwdata"},    PWDATA, 0);
    chk({tag, "_penable"},   32'(PENABLE), 0);
  endtask

  // Slave model: PREADY from the ready_at-th ACCESS cycle onward, or always when stale.
  always @(negedge PCLK) begin
    if (PSELx[0] && PENABLE) acc_n = acc_n + 1;
    else                     acc_n = 0;
    PREADY  = stale_ready || (ready_at != 0 && acc_n >= ready_at);
    PRDATA  = slave_rdata;
    PSLVERR = slave_err;
  end

  always @(negedge PCLK) begin
    if (!PRESETn) begin
      mon_acc   = 0;
      mon_setup = 0;
    end else begin
      if (PSELx != '0) begin
        if (PENABLE) mon_acc++;
        else begin
          mon_setup++;
          last_gap = cyc - last_rsp_cyc;
        end
        chk("busy_in_xfer", 32'(busy), 1);
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL psel_without_cmd: got PSELx=%0b expected no transfer", PSELx);
        end else begin
          chk("paddr",  32'(PADDR),  32'(exp_q[0].addr));
          chk("pwrite", 32'(PWRITE), 32'(exp_q[0].wr));
          chk("pwdata", PWDATA,      exp_q[0].wdata);
        end
      end
      if (rsp_valid) begin
        rsp_count++;
        last_rsp_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_err",       32'(rsp_err), 32'(e.err));
          chk("rsp_rdata",     rsp_rdata, e.rdata);
          chk("access_cycles", mon_acc, e.acc);
          chk("setup_cycles",  mon_setup, e.setup);
          chk("latency",       cyc - e.acc_cyc, e.setup + e.acc);
          chk("rsp_psel",      32'(PSELx), 0);
          chk("rsp_penable",   32'(PENABLE), 0);
          chk("rsp_cmd_ready", 32'(cmd_ready), 1);
          chk("rsp_busy",      32'(busy), 0);
        end
        mon_acc   = 0;
        mon_setup = 0;
      end
    end
  end

  task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input logic x_err, input logic [DW-1:0] x_rd, input int x_acc,
                      input int x_setup);
    exp_t x;
    int   n = 0;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    while (!cmd_ready && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_accept: got cmd_ready=0 expected 1 within 200 cycles");
      cmd_valid = 1'b0;
      return;
    end
    x.wr = wr; x.addr = addr; x.wdata = wd; x.err = x_err; x.rdata = x_rd;
    x.acc = x_acc; x.setup = x_setup; x.acc_cyc = cyc + 1;
    exp_q.push_back(x);
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge PCLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_wait: got %0d pending responses expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge PCLK);
  endtask

  initial begin
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    #23;
    chk_all_zero("reset");
    @(negedge PCLK); PRESETn = 1'b1;
    @(negedge PCLK);
    chk("cmd_ready_after_reset", 32'(cmd_ready), 1);
    chk("busy_after_reset", 32'(busy), 0);

    // Write, PREADY on the third ACCESS cycle
    ready_at = 3;
    send(1'b1, 16'h0040, 32'hDEAD_BEEF, 1'b0, 32'h0, 3, 1); wait_rsp();
    // Read, early PREADY masked until ACCESS cycle 3
    ready_at = 1; slave_rdata = 32'hDEAD_BEEF;
    send(1'b0, 16'h0040, 32'h0, 1'b0, 32'hDEAD_BEEF, 3, 1); wait_rsp();
    // Stale PREADY held high across idle
    stale_ready = 1'b1; slave_rdata = 32'h1234_5678;
    send(1'b0, 16'h0010, 32'h0, 1'b0, 32'h1234_5678, 3, 1); wait_rsp();
    stale_ready = 1'b0;
    // Longer wait, top in-range address
    ready_at = 5;
    send(1'b1, 16'h3FFC, 32'hA5A5_5A5A, 1'b0, 32'h0, 5, 1); wait_rsp();
    // Slave error on a read zeroes data
    ready_at = 4; slave_err = 1'b1; slave_rdata = 32'h7777_7777;
    send(1'b0, 16'h0100, 32'h0, 1'b1, 32'h0, 4, 1); wait_rsp();
    slave_err = 1'b0;
    // PREADY on the last cycle before timeout wins
    ready_at = 16; slave_rdata = 32'hCAFE_F00D;
    send(1'b0, 16'h0200, 32'h0, 1'b0, 32'hCAFE_F00D, 16, 1); wait_rsp();
    // Timeout, then a normal command
    ready_at = 0;
    send(1'b0, 16'h0040, 32'h0, 1'b1, 32'h0, 16, 1); wait_rsp();
    ready_at = 2; slave_rdata = 32'h0BAD_F00D;
    send(1'b0, 16'h0044, 32'h0, 1'b0, 32'h0BAD_F00D, 3, 1); wait_rsp();
    // Decode errors: no bus activity, response on the next cycle
    send(1'b1, 16'h4000, 32'h1111_1111, 1'b1, 32'h0, 0, 0); wait_rsp();
    send(1'b0, 16'hC004, 32'h0, 1'b1, 32'h0, 0, 0); wait_rsp();
    // Back-to-back commands
    ready_at = 1; slave_rdata = 32'h55AA_33CC;
    send(1'b1, 16'h0080, 32'h0102_0304, 1'b0, 32'h0, 3, 1);
    send(1'b0, 16'h0084, 32'h0, 1'b0, 32'h55AA_33CC, 3, 1);
    wait_rsp();
    chk("b2b_psel_gap", last_gap, 1);
    // Reset during ACCESS
    ready_at = 0;
    send(1'b0, 16'h0040, 32'h0, 1'b1, 32'h0, 16, 1);
    begin
      int n = 0;
      while (!PENABLE && n < 20) begin
        @(negedge PCLK);
        n++;
      end
    end
    chk("penable_before_reset", 32'(PENABLE), 1);
    #2;
    snap = rsp_count;
    PRESETn = 1'b0;
    #1;
    chk_all_zero("midrst");
    exp_q.delete();
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (4) @(negedge PCLK);
    chk("no_rsp_after_reset", rsp_count, snap);
    ready_at = 1; slave_rdata = 32'h600D_CAFE;
    send(1'b0, 16'h0044, 32'h0, 1'b0, 32'h600D_CAFE, 3, 1); wait_rsp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion before 200000 ns");
    $fatal(1);
  end

endmodule
